ray_dir_normalizer: RTL and testbench
=====================================

# ray_dir_normalizer

Sequential fixed-point normaliser that sits directly downstream of the per-core ray generator. It accepts one raw signed 12-bit ray direction plus its pixel loop index over a valid/ready handshake, and computes the unit direction in Q1.10 using a bit-serial integer square root and a restoring divider. It presents the result to the traversal core over a second valid/ready handshake. The generator's `ready_internal` is driven from `in_ready`; the generator's `val_dir` is driven from the accept strobe `in_valid && in_ready`.

## Interface
- No parameters; all widths fixed.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  raw direction and index are valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `ray_dir_x`, `ray_dir_y`, `ray_dir_z`  in  12 each  signed raw direction components.
- `loop_index`  in  32  signed pixel index; carried through unchanged.
- `out_valid`  out  1  normalised result valid.
- `out_ready`  in  1  consumer accepts result.
- `norm_dir_x`, `norm_dir_y`, `norm_dir_z`  out  12 each  signed Q1.10 unit direction; 1.0 = 1024.
- `out_loop_index`  out  32  index captured with the input.
- `out_zero`  out  1  input vector was (0,0,0); norm outputs are 0.

## Operation
- States: IDLE, SQUARE, SQRT, DIV, OUT.
- **IDLE.** `in_ready` = 1. When `in_valid` is high, capture the components, their signs, their magnitudes (12-bit unsigned; |−2048| = 2048) and `loop_index`, then go to SQUARE.
- **SQUARE.** Compute mag2 = x² + y² + z² as 24-bit unsigned; the maximum is 12582912.
  - If mag2 == 0: set `out_zero` = 1, set norms to 0, go to OUT.
  - Otherwise go to SQRT.
- **SQRT.** Restoring digit-by-digit integer square root, one result bit per cycle, 12 cycles.
  - mag = floor(sqrt(mag2)), 12-bit unsigned, mag ≥ 1.
- **DIV.** Restoring division q = (|c| << 10) / mag, 11 quotient bits, one bit per cycle.
  - Components are processed in order x, y, z: 33 cycles total.
  - Quotient truncates toward zero. Since |c| ≤ mag, q ≤ 1024.
  - The result is negated if the input component was negative.
- **OUT.**
  - `out_valid` = 1; all outputs are held stable until `out_ready`.
  - On `out_valid && out_ready`: go to IDLE and clear `out_zero`.
- No overlap between rays: one ray in flight; `in_ready` is low in every state other than IDLE.
- `in_valid` is ignored outside IDLE; input ports are not sampled after capture.
- Reset values: state IDLE; `in_ready` = 1; `out_valid` = 0; norms 0; `out_loop_index` 0; `out_zero` 0; all internal datapath registers 0.

## Timing
- Edge E0 accepts the input (`in_valid && in_ready`).
- SQUARE completes at E1.
- SQRT occupies E2–E13.
- DIV occupies E14–E46.
- `out_valid` goes high after E46: latency 46 edges from accept to valid.
- Zero vector: `out_valid` goes high after E1.
- `in_ready` drops the cycle after E0. It returns high the cycle after the edge on which `out_valid && out_ready` is true. Minimum issue interval is 48 cycles.
- `out_ready` held high while in OUT: the transfer takes one cycle.
- `out_ready` low: OUT persists indefinitely with no output change.
- Asserting `reset_n` low at any point, including mid-SQRT or mid-DIV, returns the block to its reset values immediately, independent of `clk`. The in-flight ray is discarded and no `out_valid` pulse is produced for it.

## Test plan
- Unit axis: in (1024,0,0), idx 7 → after 46 edges, out (1024,0,0), idx 7, `out_zero` 0.
- Pythagorean: (3,4,0) → mag2 25, mag 5, out (614,819,0). Then (−3,0,4) → (−614,0,819).
- Extreme: (−2048,−2048,−2048) → mag2 12582912, mag 3547, out (−591,−591,−591); no overflow.
- Zero vector: (0,0,0), idx 42 → `out_valid` after E1, norms 0, `out_zero` 1, idx 42.
- Backpressure: hold `out_ready` low for 10 cycles in OUT, and drive `in_valid` high with a different vector → outputs stable, `in_ready` 0, second vector not captured until the block returns to IDLE.
- Reset mid-operation: pull `reset_n` low at E20 → `out_valid` 0 and `in_ready` 1 immediately. After release, a new ray (0,5,0) yields (0,1024,0) with the correct latency.

Source files
------------

// File: rtl/ray_dir_normalizer.sv
// ============================================================================
// ray_dir_normalizer : bit-serial Q1.10 normaliser for signed 12-bit ray dirs
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module ray_dir_normalizer (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [11:0] ray_dir_x,
  input  logic signed [11:0] ray_dir_y,
  input  logic signed [11:0] ray_dir_z,
  input  logic signed [31:0] loop_index,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [11:0] norm_dir_x,
  output logic signed [11:0] norm_dir_y,
  output logic signed [11:0] norm_dir_z,
  output logic signed [31:0] out_loop_index,
  output logic               out_zero
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SQUARE = 3'd1,
    S_SQRT   = 3'd2,
    S_DIV    = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t r_state, w_state_next;

  logic               r_sx, r_sy, r_sz;
  logic [11:0]        r_mx, r_my, r_mz;
  logic signed [31:0] r_idx;
  logic [23:0]        r_rad;
  logic [13:0]        r_rem;
  logic [11:0]        r_root;
  logic [3:0]         r_cnt;
  logic [1:0]         r_comp;
  logic [11:0]        r_drem;
  logic [10:0]        r_dbits;
  logic [9:0]         r_q;
  logic signed [11:0] r_nx, r_ny, r_nz;
  logic               r_zero;

  logic [11:0] w_ax, w_ay, w_az;
  logic [23:0] w_mx24, w_my24, w_mz24, w_mag2;
  logic [15:0] w_srem_try, w_sroot_try;
  logic        w_sge;
  logic [13:0] w_srem_next;
  logic [11:0] w_sroot_next;
  logic [12:0] w_dtry;
  logic        w_dge;
  logic [11:0] w_drem_next;
  logic [10:0] w_q;
  logic [11:0] w_qext, w_nval, w_mnext;
  logic        w_sign;

  assign w_ax = ray_dir_x[11] ? (~$unsigned(ray_dir_x) + 12'd1) : $unsigned(ray_dir_x);
  assign w_ay = ray_dir_y[11] ? (~$unsigned(ray_dir_y) + 12'd1) : $unsigned(ray_dir_y);
  assign w_az = ray_dir_z[11] ? (~$unsigned(ray_dir_z) + 12'd1) : $unsigned(ray_dir_z);

  assign w_mx24 = {12'd0, r_mx};
  assign w_my24 = {12'd0, r_my};
  assign w_mz24 = {12'd0, r_mz};
  assign w_mag2 = w_mx24 * w_mx24 + w_my24 * w_my24 + w_mz24 * w_mz24;

  // One root bit per cycle: trial subtract (4*root + 1) from the shifted remainder
  assign w_srem_try   = {r_rem, r_rad[23:22]};
  assign w_sroot_try  = {2'b00, r_root, 2'b01};
  assign w_sge        = (w_srem_try >= w_sroot_try);
  assign w_srem_next  = w_sge ? 14'(w_srem_try - w_sroot_try) : w_srem_try[13:0];
  assign w_sroot_next = {r_root[10:0], w_sge};

  assign w_dtry      = {r_drem, r_dbits[10]};
  assign w_dge       = (w_dtry >= {1'b0, r_root});
  assign w_drem_next = w_dge ? 12'(w_dtry - {1'b0, r_root}) : w_dtry[11:0];
  assign w_q         = {r_q, w_dge};
  assign w_qext      = {1'b0, w_q};
  assign w_sign      = (r_comp == 2'd0) ? r_sx : ((r_comp == 2'd1) ? r_sy : r_sz);
  assign w_nval      = w_sign ? (~w_qext + 12'd1) : w_qext;
  assign w_mnext     = (r_comp == 2'd0) ? r_my : r_mz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_state_next = S_SQUARE;
      S_SQUARE: w_state_next = (w_mag2 == 24'd0) ? S_OUT : S_SQRT;
      S_SQRT:   if (r_cnt == 4'd11) w_state_next = S_DIV;
      S_DIV:    if (r_cnt == 4'd10 && r_comp == 2'd2) w_state_next = S_OUT;
      S_OUT:    if (out_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sx <= 1'b0;  r_sy <= 1'b0;  r_sz <= 1'b0;
      r_mx <= '0;    r_my <= '0;    r_mz <= '0;
      r_idx <= '0;   r_rad <= '0;   r_rem <= '0;  r_root <= '0;
      r_cnt <= '0;   r_comp <= '0;  r_drem <= '0; r_dbits <= '0;
      r_q <= '0;     r_nx <= '0;    r_ny <= '0;   r_nz <= '0;
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_sx  <= ray_dir_x[11];
          r_sy  <= ray_dir_y[11];
          r_sz  <= ray_dir_z[11];
          r_mx  <= w_ax;
          r_my  <= w_ay;
          r_mz  <= w_az;
          r_idx <= loop_index;
        end
        S_SQUARE: begin
          r_rad  <= w_mag2;
          r_rem  <= '0;
          r_root <= '0;
          r_cnt  <= '0;
          if (w_mag2 == 24'd0) begin
            r_zero <= 1'b1;
            r_nx   <= '0;
            r_ny   <= '0;
            r_nz   <= '0;
          end
        end
        S_SQRT: begin
          r_rem  <= w_srem_next;
          r_root <= w_sroot_next;
          r_rad  <= {r_rad[21:0], 2'b00};
          if (r_cnt == 4'd11) begin
            // Dividend is |x| << 10; its bits above the 11 quotient positions seed the remainder
            r_cnt   <= '0;
            r_comp  <= '0;
            r_q     <= '0;
            r_drem  <= {1'b0, r_mx[11:1]};
            r_dbits <= {r_mx[0], 10'd0};
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DIV: begin
          if (r_cnt == 4'd10) begin
            case (r_comp)
              2'd0:    r_nx <= w_nval;
              2'd1:    r_ny <= w_nval;
              default: r_nz <= w_nval;
            endcase
            r_cnt   <= '0;
            r_comp  <= (r_comp == 2'd2) ? 2'd0 : r_comp + 2'd1;
            r_q     <= '0;
            r_drem  <= {1'b0, w_mnext[11:1]};
            r_dbits <= {w_mnext[0], 10'd0};
          end else begin
            r_cnt   <= r_cnt + 4'd1;
            r_q     <= w_q[9:0];
            r_drem  <= w_drem_next;
            r_dbits <= {r_dbits[9:0], 1'b0};
          end
        end
        S_OUT: if (out_ready) r_zero <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready       = (r_state == S_IDLE);
  assign out_valid      = (r_state == S_OUT);
  assign norm_dir_x     = r_nx;
  assign norm_dir_y     = r_ny;
  assign norm_dir_z     = r_nz;
  assign out_loop_index = r_idx;
  assign out_zero       = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_ray_dir_normalizer.sv
// ============================================================================
// tb_ray_dir_normalizer : scoreboard bench with randomized and directed rays
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_ray_dir_normalizer;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [11:0] ray_dir_x = '0, ray_dir_y = '0, ray_dir_z = '0;
  logic signed [31:0] loop_index = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [11:0] norm_dir_x, norm_dir_y, norm_dir_z;
  logic signed [31:0] out_loop_index;
  logic               out_zero;

  ray_dir_normalizer dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .ray_dir_z(ray_dir_z),
    .loop_index(loop_index), .out_valid(out_valid), .out_ready(out_ready),
    .norm_dir_x(norm_dir_x), .norm_dir_y(norm_dir_y), .norm_dir_z(norm_dir_z),
    .out_loop_index(out_loop_index), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nx, ny, nz;
    int idx;
    bit zero;
    int acc;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rdy_mode = 1;   // 0 random, 1 high, 2 low
  bit   head_seen = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact integer sqrt and truncating division on magnitudes
  function automatic exp_t model(input int x, input int y, input int z, input int idx, input int acc);
    exp_t e;
    int m2, m;
    int v[3];
    int q[3];
    v[0] = x; v[1] = y; v[2] = z;
    m2 = x * x + y * y + z * z;
    e.idx = idx;
    e.acc = acc;
    if (m2 == 0) begin
      e.zero = 1; e.nx = 0; e.ny = 0; e.nz = 0; e.lat = 1;
      return e;
    end
    m = int'($sqrt(real'(m2)));
    while (m * m > m2) m--;
    while ((m + 1) * (m + 1) <= m2) m++;
    for (int i = 0; i < 3; i++) begin
      q[i] = ((v[i] < 0 ? -v[i] : v[i]) * 1024) / m;
      if (v[i] < 0) q[i] = -q[i];
    end
    e.zero = 0; e.nx = q[0]; e.ny = q[1]; e.nz = q[2]; e.lat = 46;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      head_seen = 0;
    end else if (out_valid) begin
      if (!head_seen) begin
        head_seen = 1;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: got idx %0d expected none", out_loop_index);
        end else begin
          chk("latency", cyc - sb[0].acc, sb[0].lat);
        end
      end
      if (sb.size() > 0) begin
        if (out_ready) begin
          chk("norm_x", norm_dir_x, sb[0].nx);
          chk("norm_y", norm_dir_y, sb[0].ny);
          chk("norm_z", norm_dir_z, sb[0].nz);
          chk("index", out_loop_index, sb[0].idx);
          chk("zero", out_zero, sb[0].zero);
          void'(sb.pop_front());
          head_seen = 0;
        end else begin
          chk("hold_stable",
              {norm_dir_x, norm_dir_y, norm_dir_z, out_zero},
              {12'(sb[0].nx), 12'(sb[0].ny), 12'(sb[0].nz), sb[0].zero});
        end
      end else if (out_ready) begin
        head_seen = 0;
      end
    end
  end

  task automatic issue(input int x, input int y, input int z, input int idx);
    bit got = 0;
    @(posedge clk); #1;
    in_valid   = 1'b1;
    ray_dir_x  = 12'(x);
    ray_dir_y  = 12'(y);
    ray_dir_z  = 12'(z);
    loop_index = idx;
    for (int w = 0; w < 400 && !got; w++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(x, y, z, idx, cyc + 1));
        got = 1;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    ray_dir_x  = 12'($urandom);
    ray_dir_y  = 12'($urandom);
    ray_dir_z  = 12'($urandom);
    loop_index = $urandom;
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || out_valid) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_r;
    int w;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_norm_x", norm_dir_x, 0);
    chk("rst_index", out_loop_index, 0);
    chk("rst_zero", out_zero, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    issue(1024, 0, 0, 7);
    drain();
    issue(3, 4, 0, 1);
    issue(-3, 0, 4, 2);
    issue(-2048, -2048, -2048, 3);
    issue(0, 0, 0, 42);
    issue(2047, -1, 1, -5);
    drain();

    // Backpressure with a competing input held valid
    rdy_mode = 2;
    issue(-700, 300, 55, 100);
    @(posedge clk); #1;
    in_valid = 1'b1; ray_dir_x = 12'sd9; ray_dir_y = 12'sd0; ray_dir_z = -12'sd12; loop_index = 101;
    w = 0;
    while (!out_valid && w < 200) begin @(negedge clk); w++; end
    chk("bp_valid_seen", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
    end
    rdy_mode = 1;
    issue(9, 0, -12, 101);
    drain();

    // Asynchronous reset mid-division
    issue(100, 200, 300, 55);
    acc_r = sb[sb.size() - 1].acc;
    while (cyc < acc_r + 20) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_norm_x", norm_dir_x, 0);
    chk("arst_index", out_loop_index, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    issue(0, 5, 0, 9);
    drain();

    // Randomized rays with random consumer stalls
    rdy_mode = 0;
    for (int n = 0; n < 24; n++) begin
      int x, y, z;
      if ($urandom_range(0, 3) == 0) begin
        x = int'($urandom_range(0, 16)) - 8;
        y = int'($urandom_range(0, 16)) - 8;
        z = int'($urandom_range(0, 16)) - 8;
      end else begin
        x = int'($urandom_range(0, 4095)) - 2048;
        y = int'($urandom_range(0, 4095)) - 2048;
        z = int'($urandom_range(0, 4095)) - 2048;
      end
      issue(x, y, z, int'($urandom));
    end
    drain();
    rdy_mode = 1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
